// File: rtl/axi_pkg.sv
// axi_pkg: AXI4-Stream video beat definitions.
//   AXIS_DATA_W      - TDATA width (RGB565)
//   axi4s_payload_t  - one beat: TDATA, TUSER (start of frame), TLAST (end of line)
package axi_pkg;

   localparam int AXIS_DATA_W = 16;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] tdata;
      logic                   tuser;
      logic                   tlast;
   } axi4s_payload_t;

endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: shared video definitions.
//   pattern_t     - test-pattern selector (SOLID, BARS, CHECKER, RAMP)
//   RGB565_*      - colour constants used by the pattern generator
//   bar_color()   - maps a colour-bar index (0..7) to its RGB565 colour
package vga_pkg;

   typedef enum logic [1:0] {
      PAT_SOLID   = 2'd0,
      PAT_BARS    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_RAMP    = 2'd3
   } pattern_t;

   localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB565_RED     = 16'hF800;
   localparam logic [15:0] RGB565_BLUE    = 16'h001F;
   localparam logic [15:0] RGB565_BLACK   = 16'h0000;

   // Classic colour-bar order, left to right.
   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = RGB565_WHITE;
         3'd1:    c = RGB565_YELLOW;
         3'd2:    c = RGB565_CYAN;
         3'd3:    c = RGB565_GREEN;
         3'd4:    c = RGB565_MAGENTA;
         3'd5:    c = RGB565_RED;
         3'd6:    c = RGB565_BLUE;
         default: c = RGB565_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/axi4s_if.sv
// axi4s_if: AXI4-Stream video bundle.
//   tdata/tuser/tlast/tvalid driven by the master, tready by the slave.
interface axi4s_if;

   logic [axi_pkg::AXIS_DATA_W-1:0] tdata;
   logic                            tuser;
   logic                            tlast;
   logic                            tvalid;
   logic                            tready;

   modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);

endinterface

// File: rtl/pattern_pixel_color.sv
// pattern_pixel_color: combinational RGB565 colour for one pixel.
//   pattern     - selected test pattern
//   x, y        - pixel coordinates inside the active area
//   bar_idx     - colour-bar index (kept by the caller's counter, no divide here)
//   solid_color - colour used by the SOLID pattern
//   color       - resulting RGB565 pixel
module pattern_pixel_color
   import vga_pkg::*;
#(
   parameter int XW = 10,
   parameter int YW = 9
) (
   input  pattern_t        pattern,
   input  logic [XW-1:0]   x,
   input  logic [YW-1:0]   y,
   input  logic [2:0]      bar_idx,
   input  logic [15:0]     solid_color,
   output logic [15:0]     color
);

   // Coordinates widened/truncated to 16 bits: the ramp is defined mod 2^16
   // and the checker needs bit 5 even when the counters are narrower.
   logic [15:0] x16;
   logic [15:0] y16;

   always_comb begin
      x16   = 16'(x);
      y16   = 16'(y);
      color = RGB565_BLACK;
      case (pattern)
         PAT_SOLID:   color = solid_color;
         PAT_BARS:    color = bar_color(bar_idx);
         PAT_CHECKER: color = (x16[5] ^ y16[5]) ? RGB565_WHITE : RGB565_BLACK;
         PAT_RAMP:    color = x16 + y16;
         default:     color = RGB565_BLACK;
      endcase
   end

endmodule

// File: rtl/axis_frame_source.sv
// axis_frame_source: AXI4-Stream RGB565 test-frame generator.
//   axi_clk      - clock
//   axi_rstn     - asynchronous active-low reset
//   enable       - keep producing frames while high (frames are never cut short)
//   pattern_sel  - pattern for the next frame (sampled at frame start)
//   solid_color  - colour for the SOLID pattern (sampled at frame start)
//   m_axis       - video stream: TUSER = start of frame, TLAST = end of line
//   frame_done   - one-cycle pulse after the last beat of a frame
//   frame_count  - number of completed frames (wraps)
module axis_frame_source
   import vga_pkg::*;
   import axi_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int GAP_CYCLES = 16
) (
   input  logic         axi_clk,
   input  logic         axi_rstn,
   input  logic         enable,
   input  logic [1:0]   pattern_sel,
   input  logic [15:0]  solid_color,
   axi4s_if.master      m_axis,
   output logic         frame_done,
   output logic [31:0]  frame_count
);

   localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP} state_t;

   state_t          state_reg,       state_next;
   logic [XW-1:0]   x_reg,           x_next;
   logic [YW-1:0]   y_reg,           y_next;
   logic [BW-1:0]   bar_cnt_reg,     bar_cnt_next;
   logic [2:0]      bar_idx_reg,     bar_idx_next;
   logic [GW-1:0]   gap_cnt_reg,     gap_cnt_next;
   pattern_t        pattern_reg,     pattern_next;
   logic [15:0]     solid_reg,       solid_next;
   logic            tvalid_reg,      tvalid_next;
   axi4s_payload_t  payload_reg,     payload_next;
   logic            frame_done_reg,  frame_done_next;
   logic [31:0]     frame_count_reg, frame_count_next;

   logic            beat_fire;
   logic            x_last;
   logic            frame_last;
   logic            start_frame;   // first beat of a new frame goes on the bus
   logic            advance;       // next beat within the same frame
   logic [15:0]     pixel_color;

   // ---------------------------------------------------------------------
   // Control: state, coordinates, frame bookkeeping
   // ---------------------------------------------------------------------
   always_comb begin
      state_next       = state_reg;
      x_next           = x_reg;
      y_next           = y_reg;
      bar_cnt_next     = bar_cnt_reg;
      bar_idx_next     = bar_idx_reg;
      gap_cnt_next     = gap_cnt_reg;
      pattern_next     = pattern_reg;
      solid_next       = solid_reg;
      frame_done_next  = 1'b0;
      frame_count_next = frame_count_reg;
      start_frame      = 1'b0;
      advance          = 1'b0;

      // TVALID is 1 for the whole ACTIVE state, so the handshake is just TREADY.
      beat_fire  = (state_reg == ST_ACTIVE) && m_axis.tready;
      x_last     = (x_reg == X_LAST);
      frame_last = x_last && (y_reg == Y_LAST);

      case (state_reg)
         ST_IDLE: begin
            if (enable) begin
               state_next  = ST_ACTIVE;
               start_frame = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (beat_fire) begin
               if (frame_last) begin
                  frame_done_next  = 1'b1;
                  frame_count_next = frame_count_reg + 32'd1;
                  x_next           = '0;
                  y_next           = '0;
                  bar_cnt_next     = '0;
                  bar_idx_next     = '0;
                  if (GAP_CYCLES > 0) begin
                     state_next   = ST_GAP;
                     gap_cnt_next = '0;
                  end else if (enable) begin
                     start_frame  = 1'b1;
                  end else begin
                     state_next   = ST_IDLE;
                  end
               end else begin
                  advance = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               if (enable) begin
                  state_next  = ST_ACTIVE;
                  start_frame = 1'b1;
               end else begin
                  state_next  = ST_IDLE;
               end
            end else begin
               gap_cnt_next = gap_cnt_reg + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (start_frame) begin
         // Pattern and colour are frozen for the whole frame from here.
         x_next       = '0;
         y_next       = '0;
         bar_cnt_next = '0;
         bar_idx_next = '0;
         pattern_next = pattern_t'(pattern_sel);
         solid_next   = solid_color;
      end else if (advance) begin
         if (x_last) begin
            x_next       = '0;
            y_next       = y_reg + 1'b1;
            bar_cnt_next = '0;
            bar_idx_next = '0;
         end else begin
            x_next = x_reg + 1'b1;
            // Bar index steps every H_ACTIVE/8 pixels without a divider.
            if (bar_cnt_reg == BAR_LAST) begin
               bar_cnt_next = '0;
               bar_idx_next = bar_idx_reg + 3'd1;
            end else begin
               bar_cnt_next = bar_cnt_reg + 1'b1;
            end
         end
      end
   end

   // Colour of the beat that will be on the bus next cycle.
   pattern_pixel_color #(
      .XW (XW),
      .YW (YW)
   ) u_color (
      .pattern     (pattern_next),
      .x           (x_next),
      .y           (y_next),
      .bar_idx     (bar_idx_next),
      .solid_color (solid_next),
      .color       (pixel_color)
   );

   // ---------------------------------------------------------------------
   // Beat payload: only reloaded when a new beat is due, so it holds
   // steady through back-pressure and TREADY never reaches an output.
   // ---------------------------------------------------------------------
   always_comb begin
      payload_next = payload_reg;
      tvalid_next  = (state_next == ST_ACTIVE);
      if (start_frame || advance) begin
         payload_next.tdata = pixel_color;
         payload_next.tuser = (x_next == '0) && (y_next == '0);
         payload_next.tlast = (x_next == X_LAST);
      end else if (state_next != ST_ACTIVE) begin
         payload_next = '0;
      end
   end

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         state_reg       <= ST_IDLE;
         x_reg           <= '0;
         y_reg           <= '0;
         bar_cnt_reg     <= '0;
         bar_idx_reg     <= '0;
         gap_cnt_reg     <= '0;
         pattern_reg     <= PAT_SOLID;
         solid_reg       <= '0;
         tvalid_reg      <= 1'b0;
         payload_reg     <= '0;
         frame_done_reg  <= 1'b0;
         frame_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         x_reg           <= x_next;
         y_reg           <= y_next;
         bar_cnt_reg     <= bar_cnt_next;
         bar_idx_reg     <= bar_idx_next;
         gap_cnt_reg     <= gap_cnt_next;
         pattern_reg     <= pattern_next;
         solid_reg       <= solid_next;
         tvalid_reg      <= tvalid_next;
         payload_reg     <= payload_next;
         frame_done_reg  <= frame_done_next;
         frame_count_reg <= frame_count_next;
      end
   end

   assign m_axis.tvalid = tvalid_reg;
   assign m_axis.tdata  = payload_reg.tdata;
   assign m_axis.tuser  = payload_reg.tuser;
   assign m_axis.tlast  = payload_reg.tlast;
   assign frame_done    = frame_done_reg;
   assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_axis_frame_source.sv
// tb_axis_frame_source: self-checking bench for axis_frame_source
// (16x4 frames). A scoreboard queue is filled with the model's beats when a
// frame is requested and drained by a monitor on every handshake.
module tb_axis_frame_source;

   localparam int H   = 16;
   localparam int V   = 4;
   localparam int GAP = 3;

   localparam logic [1:0] P_SOLID   = 2'd0;
   localparam logic [1:0] P_BARS    = 2'd1;
   localparam logic [1:0] P_CHECKER = 2'd2;
   localparam logic [1:0] P_RAMP    = 2'd3;

   typedef struct {
      logic [15:0] data;
      logic        user;
      logic        last;
      logic        eof;
   } beat_t;

   typedef struct {
      logic [1:0]  pat;
      logic [15:0] solid;
      int          pct;
      int          drop_at;
      logic [1:0]  alt_pat;
      logic [15:0] first_exp;
      logic [15:0] last_exp;
   } vec_t;

   logic        clk;
   logic        rstn;
   logic        enable;
   logic        en_b;
   logic [1:0]  pattern_sel;
   logic [15:0] solid_color;
   logic        ready;
   logic        frame_done, frame_done_b;
   logic [31:0] frame_count, frame_count_b;
   int          ready_pct = 100;

   axi4s_if a_if ();
   axi4s_if b_if ();
   assign a_if.tready = ready;
   assign b_if.tready = ready;

   axis_frame_source #(.H_ACTIVE(H), .V_ACTIVE(V), .GAP_CYCLES(GAP)) dut (
      .axi_clk     (clk),
      .axi_rstn    (rstn),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .solid_color (solid_color),
      .m_axis      (a_if),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   axis_frame_source #(.H_ACTIVE(H), .V_ACTIVE(V), .GAP_CYCLES(0)) dut_b (
      .axi_clk     (clk),
      .axi_rstn    (rstn),
      .enable      (en_b),
      .pattern_sel (pattern_sel),
      .solid_color (solid_color),
      .m_axis      (b_if),
      .frame_done  (frame_done_b),
      .frame_count (frame_count_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // TREADY changes just after each rising edge.
   initial begin
      ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_pct >= 100) ready = 1'b1;
         else                  ready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   beat_t       exp_q[$];
   bit          mon_on = 1'b0;
   int          beats_seen = 0;
   logic [31:0] cnt_exp = '0;
   logic        done_exp = 1'b0;
   logic        eof_pending = 1'b0;
   logic        stall_prev = 1'b0;
   logic [17:0] prev_pl;
   logic [15:0] first_seen, last_seen;
   beat_t       mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [15:0] model_px(input logic [1:0] pat, input logic [15:0] solid,
                                            input int x, input int y);
      logic [15:0] r;
      case (pat)
         P_SOLID: r = solid;
         P_BARS: begin
            case (x / (H / 8))
               0:       r = 16'hFFFF;
               1:       r = 16'hFFE0;
               2:       r = 16'h07FF;
               3:       r = 16'h07E0;
               4:       r = 16'hF81F;
               5:       r = 16'hF800;
               6:       r = 16'h001F;
               default: r = 16'h0000;
            endcase
         end
         P_CHECKER: r = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
         default:   r = 16'(x + y);
      endcase
      return r;
   endfunction

   task automatic push_frame(input logic [1:0] pat, input logic [15:0] solid);
      beat_t b;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            b.data = model_px(pat, solid, x, y);
            b.user = (x == 0) && (y == 0);
            b.last = (x == H - 1);
            b.eof  = (x == H - 1) && (y == V - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   // Monitor: sample half a period away from the active edge.
   always @(negedge clk) begin
      if (mon_on) begin
         if (eof_pending) begin
            done_exp    = 1'b1;
            cnt_exp     = cnt_exp + 32'd1;
            eof_pending = 1'b0;
         end else begin
            done_exp = 1'b0;
         end
         check("done_count", {frame_done, frame_count}, {done_exp, cnt_exp});
         if (stall_prev)
            check("stall_hold", {a_if.tvalid, a_if.tuser, a_if.tlast, a_if.tdata},
                  {1'b1, prev_pl});
         if (a_if.tvalid && a_if.tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", a_if.tvalid, 1'b0);
            end else begin
               mon_e = exp_q.pop_front();
               check($sformatf("beat%0d", beats_seen), {a_if.tuser, a_if.tlast, a_if.tdata},
                     {mon_e.user, mon_e.last, mon_e.data});
               if (mon_e.user) first_seen = a_if.tdata;
               if (mon_e.eof) begin
                  last_seen   = a_if.tdata;
                  eof_pending = 1'b1;
               end
            end
            beats_seen++;
         end
         stall_prev = a_if.tvalid && !a_if.tready;
         prev_pl    = {a_if.tuser, a_if.tlast, a_if.tdata};
      end
   end

   task automatic wait_beats(input int n, input int budget);
      int cnt = 0;
      while (beats_seen < n && cnt < budget) begin
         tick();
         cnt++;
      end
      if (beats_seen < n) check("beat_timeout", beats_seen, n);
   endtask

   task automatic wait_done(input int budget);
      int cnt = 0;
      while (frame_done !== 1'b1 && cnt < budget) begin
         tick();
         cnt++;
      end
      check("done_seen", frame_done, 1'b1);
   endtask

   task automatic idle_check();
      repeat (GAP + 3) tick();
      check("idle_tvalid", a_if.tvalid, 1'b0);
   endtask

   task automatic run_frame(input vec_t v);
      int base;
      logic [31:0] fc0;
      pattern_sel = v.pat;
      solid_color = v.solid;
      ready_pct   = v.pct;
      first_seen  = 16'hDEAD;
      last_seen   = 16'hDEAD;
      push_frame(v.pat, v.solid);
      fc0  = cnt_exp;
      base = beats_seen;
      enable = 1'b1;
      wait_beats(base + v.drop_at, 3000);
      // Drop enable and change the pattern mid-frame: neither may affect it.
      enable      = 1'b0;
      pattern_sel = v.alt_pat;
      solid_color = ~v.solid;
      wait_done(3000);
      check("first_px", first_seen, v.first_exp);
      check("last_px", last_seen, v.last_exp);
      check("frame_count", frame_count, fc0 + 32'd1);
      check("queue_empty", exp_q.size(), 0);
      idle_check();
      $display("frame pat=%0d solid=%h ready=%0d%% drop@%0d first=%h last=%h count=%0d",
               v.pat, v.solid, v.pct, v.drop_at, first_seen, last_seen, frame_count);
   endtask

   initial begin
      vec_t tbl[6];
      int   base;
      int   gap;
      int   nb;
      bit   found;

      tbl[0] = '{P_SOLID,   16'h001F, 100, 1,  P_BARS,    16'h001F, 16'h001F};
      tbl[1] = '{P_BARS,    16'h0000, 100, 1,  P_BARS,    16'hFFFF, 16'h0000};
      tbl[2] = '{P_BARS,    16'h0000, 30,  1,  P_BARS,    16'hFFFF, 16'h0000};
      tbl[3] = '{P_BARS,    16'h0000, 100, 20, P_RAMP,    16'hFFFF, 16'h0000};
      tbl[4] = '{P_CHECKER, 16'h1234, 100, 1,  P_SOLID,   16'h0000, 16'h0000};
      tbl[5] = '{P_RAMP,    16'h0000, 50,  40, P_CHECKER, 16'h0000, 16'h0012};

      rstn        = 1'b1;
      enable      = 1'b0;
      en_b        = 1'b0;
      pattern_sel = P_SOLID;
      solid_color = 16'h0000;
      tick();
      rstn = 1'b0;
      repeat (2) tick();
      check("reset_outputs",
            {a_if.tvalid, a_if.tuser, a_if.tlast, a_if.tdata, frame_done, frame_count}, '0);
      rstn = 1'b1;
      tick();
      check("idle_after_reset", a_if.tvalid, 1'b0);
      mon_on = 1'b1;

      // Two back-to-back SOLID frames with enable held: check the gap length.
      solid_color = 16'hF800;
      push_frame(P_SOLID, 16'hF800);
      push_frame(P_SOLID, 16'hF800);
      base   = beats_seen;
      enable = 1'b1;
      wait_beats(base + 64, 500);
      gap = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (a_if.tvalid) break;
         gap++;
      end
      check("gap_len", gap, GAP);
      enable = 1'b0;
      wait_done(500);
      check("queue_empty_b2b", exp_q.size(), 0);
      idle_check();
      $display("two SOLID frames, gap=%0d count=%0d", gap, frame_count);

      for (int i = 0; i < 6; i++) run_frame(tbl[i]);

      // Reset in the middle of a frame.
      pattern_sel = P_SOLID;
      solid_color = 16'h07E0;
      ready_pct   = 100;
      push_frame(P_SOLID, 16'h07E0);
      base   = beats_seen;
      enable = 1'b1;
      wait_beats(base + 30, 500);
      mon_on = 1'b0;
      rstn   = 1'b0;
      #1;
      check("reset_midframe",
            {a_if.tvalid, a_if.tuser, a_if.tlast, a_if.tdata, frame_done, frame_count}, '0);
      exp_q.delete();
      eof_pending = 1'b0;
      cnt_exp     = '0;
      stall_prev  = 1'b0;
      tick();
      tick();
      push_frame(P_SOLID, 16'h07E0);
      first_seen = 16'hDEAD;
      base       = beats_seen;
      rstn       = 1'b1;
      mon_on     = 1'b1;
      check("count_after_reset", frame_count, 32'd0);
      wait_beats(base + 1, 100);
      check("first_after_reset", first_seen, 16'h07E0);
      enable = 1'b0;
      wait_done(500);
      check("count_one", frame_count, 32'd1);
      idle_check();
      $display("reset mid-frame, restart count=%0d", frame_count);

      // Zero-gap instance: RAMP frames back to back with no bubble.
      pattern_sel = P_RAMP;
      en_b        = 1'b1;
      nb          = 0;
      found       = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (b_if.tvalid) begin
            nb++;
            if (b_if.tlast && b_if.tdata == 16'd18) begin
               found = 1'b1;
               break;
            end
         end
      end
      check("b_last_found", found, 1'b1);
      check("b_last_index", nb, 64);
      check("b_last_user", b_if.tuser, 1'b0);
      tick();
      check("b_next_beat", {b_if.tvalid, b_if.tuser, b_if.tlast, b_if.tdata},
            {1'b1, 1'b1, 1'b0, 16'h0000});
      check("b_done", {frame_done_b, frame_count_b}, {1'b1, 32'd1});
      en_b = 1'b0;
      $display("zero-gap RAMP: last beat index %0d, next beat user=%0b data=%h",
               nb, b_if.tuser, b_if.tdata);

      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
